pixel_region_latency_buffer: RTL

- Parametrised next-generation pixel-region latency buffer for the CBA array.
- Captures hit words on LE into the lowest free cell and ages each cell against a programmable latency.
- A cell with L1 asserted when its age reaches the latency becomes triggered; otherwise it is freed.
- Triggered cells are read one per ReadData strobe through the column token chain. A saturating overflow counter records dropped hits.

---
 rtl/pixel_region_latency_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pixel_region_latency_buffer.sv
// Pixel-region latency buffer: stores hits, ages them against LatCnfg, and holds L1-triggered cells for token readout.
// Optional macro LATBUF_TRIG_TAG_EN adds per-cell trigger-tag storage; without it TriggeredTag is tied to 0.
module pixel_region_latency_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int LAT_W  = 9,
    parameter int TAG_W  = 5,
    parameter int OVF_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LE,
    input  logic [DATA_W-1:0] WriterData,
    input  logic              L1,
    input  logic [TAG_W-1:0]  L1Tag,
    input  logic [LAT_W-1:0]  LatCnfg,
    input  logic              PixOffCnfg,
    input  logic              TokIn,
    output logic              TokOut,
    output logic              EnOut,
    input  logic              ReadData,
    output logic [DATA_W-1:0] TriggeredData,
    output logic [TAG_W-1:0]  TriggeredTag,
    output logic              BufFull,
    output logic [OVF_W-1:0]  OvfCount
);

    typedef enum logic [1:0] {
        CELL_FREE,
        CELL_WAIT,
        CELL_TRIG
    } cell_state_e;

    cell_state_e       state_q [DEPTH];
    cell_state_e       state_d [DEPTH];
    logic [LAT_W-1:0]  age_q   [DEPTH];
    logic [LAT_W-1:0]  age_d   [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [OVF_W-1:0]  ovf_q;
    logic [OVF_W-1:0]  ovf_d;

`ifdef LATBUF_TRIG_TAG_EN
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [TAG_W-1:0]  tag_d   [DEPTH];
    logic [TAG_W-1:0]  trig_tag;
`else
    logic              unused_l1tag;
`endif

    logic [DEPTH-1:0]  free_vec;
    logic [DEPTH-1:0]  trig_vec;
    logic [DEPTH-1:0]  wr_sel;
    logic [DEPTH-1:0]  rd_sel;
    logic              wr_en;
    logic              any_trig;
    logic              en_out;
    logic              rd_fire;
    logic [DATA_W-1:0] trig_data;

    always_comb begin
        free_vec = '0;
        trig_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = (state_q[i] == CELL_FREE);
            trig_vec[i] = (state_q[i] == CELL_TRIG);
        end
    end

    // Isolate the lowest set bit: lowest free cell for writes, lowest triggered cell for reads.
    assign wr_sel   = free_vec & (~free_vec + DEPTH'(1));
    assign rd_sel   = trig_vec & (~trig_vec + DEPTH'(1));
    assign wr_en    = LE & ~PixOffCnfg;
    assign any_trig = |trig_vec;
    assign en_out   = ~TokIn & any_trig & ~PixOffCnfg;
    assign rd_fire  = en_out & ReadData;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (free_vec == '0) && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            age_d[i]   = age_q[i];
            data_d[i]  = data_q[i];
`ifdef LATBUF_TRIG_TAG_EN
            tag_d[i]   = tag_q[i];
`endif
            case (state_q[i])
                CELL_FREE: begin
                    if (wr_en && wr_sel[i]) begin
                        state_d[i] = CELL_WAIT;
                        age_d[i]   = '0;
                        data_d[i]  = WriterData;
                    end
                end
                CELL_WAIT: begin
                    if (age_q[i] == LatCnfg) begin
                        state_d[i] = L1 ? CELL_TRIG : CELL_FREE;
`ifdef LATBUF_TRIG_TAG_EN
                        if (L1) begin
                            tag_d[i] = L1Tag;
                        end
`endif
                    end else begin
                        age_d[i] = age_q[i] + LAT_W'(1);
                    end
                end
                CELL_TRIG: begin
                    if (rd_fire && rd_sel[i]) begin
                        state_d[i] = CELL_FREE;
                    end
                end
                default: state_d[i] = CELL_FREE;
            endcase
        end
    end

    always_comb begin
        trig_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel[i]) begin
                trig_data = trig_data | data_q[i];
            end
        end
    end

`ifdef LATBUF_TRIG_TAG_EN
    always_comb begin
        trig_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel[i]) begin
                trig_tag = trig_tag | tag_q[i];
            end
        end
    end
    assign TriggeredTag = trig_tag;
`else
    assign unused_l1tag = ^L1Tag;
    assign TriggeredTag = '0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= CELL_FREE;
                age_q[i]   <= '0;
                data_q[i]  <= '0;
`ifdef LATBUF_TRIG_TAG_EN
                tag_q[i]   <= '0;
`endif
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                age_q[i]   <= age_d[i];
                data_q[i]  <= data_d[i];
`ifdef LATBUF_TRIG_TAG_EN
                tag_q[i]   <= tag_d[i];
`endif
            end
            ovf_q <= ovf_d;
        end
    end

    assign TokOut        = (any_trig & ~PixOffCnfg) | TokIn;
    assign EnOut         = en_out;
    assign TriggeredData = trig_data;
    assign BufFull       = (free_vec == '0);
    assign OvfCount      = ovf_q;

endmodule
